// File: rtl/frame_bank_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_bank_ctrl : per-channel write/latest/read bank rotation so VGA      |
// |                   readout never tears against CMOS frame writes.          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module frame_bank_ctrl #(
  parameter int                ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] CH1_BASE  = 24'h000000,
  parameter logic [ADDR_W-1:0] CH2_BASE  = 24'h300000,
  parameter logic [ADDR_W-1:0] BANK_SIZE = 24'h100000
) (
  input  logic              SDRAM_oCLK,
  input  logic              RST,
  input  logic              WR1_LOAD,
  input  logic              WR2_LOAD,
  input  logic              RD1_LOAD,
  output logic [ADDR_W-1:0] WR1_ADDR,
  output logic [ADDR_W-1:0] WR2_ADDR,
  output logic [ADDR_W-1:0] RD1_ADDR1,
  output logic [ADDR_W-1:0] RD1_ADDR2,
  output logic              WR1_LOAD_O,
  output logic              WR2_LOAD_O,
  output logic              RD1_LOAD_O,
  output logic              RD1_VALID,
  output logic [7:0]        WR1_DROP_CNT,
  output logic [7:0]        WR2_DROP_CNT
);

  logic [1:0] w_wr_load;
  logic       r_rd_load_o;
  logic       r_rd_valid;

  assign w_wr_load = {WR2_LOAD, WR1_LOAD};

  for (genvar c = 0; c < 2; c++) begin : g_ch
    localparam logic [ADDR_W-1:0] c_BASE  = (c == 0) ? CH1_BASE : CH2_BASE;
    localparam logic [ADDR_W-1:0] c_ADDR0 = c_BASE;
    localparam logic [ADDR_W-1:0] c_ADDR1 = c_BASE + BANK_SIZE;
    localparam logic [ADDR_W-1:0] c_ADDR2 = c_BASE + BANK_SIZE + BANK_SIZE;

    logic [1:0]        r_w, r_l, r_r;
    logic              r_fresh, r_started, r_valid;
    logic [7:0]        r_drop;
    logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
    logic              r_load_o;

    logic [1:0]        w_w_nx, w_l_nx, w_r_nx;
    logic              w_fresh_nx, w_started_nx, w_valid_nx, w_drop_inc;

    function automatic logic [ADDR_W-1:0] bank_addr(input logic [1:0] idx);
      case (idx)
        2'd1:    bank_addr = c_ADDR1;
        2'd2:    bank_addr = c_ADDR2;
        default: bank_addr = c_ADDR0;
      endcase
    endfunction

    // Write completion is applied first, so a coincident read picks up the
    // frame that just finished (net effect: r<=w, w<=l, l<=r).
    always_comb begin
      w_w_nx       = r_w;
      w_l_nx       = r_l;
      w_r_nx       = r_r;
      w_fresh_nx   = r_fresh;
      w_started_nx = r_started | w_wr_load[c];
      w_valid_nx   = r_valid;
      w_drop_inc   = 1'b0;
      if (w_wr_load[c] && r_started) begin
        w_drop_inc = r_fresh;
        w_w_nx     = r_l;
        w_l_nx     = r_w;
        w_fresh_nx = 1'b1;
      end
      if (RD1_LOAD && w_fresh_nx) begin
        w_r_nx     = w_l_nx;
        w_l_nx     = r_r;
        w_fresh_nx = 1'b0;
        w_valid_nx = 1'b1;
      end
    end

    always_ff @(posedge SDRAM_oCLK or posedge RST) begin
      if (RST) begin
        r_w       <= 2'd0;
        r_l       <= 2'd1;
        r_r       <= 2'd2;
        r_fresh   <= 1'b0;
        r_started <= 1'b0;
        r_valid   <= 1'b0;
        r_drop    <= 8'd0;
        r_wr_addr <= c_ADDR0;
        r_rd_addr <= c_ADDR2;
        r_load_o  <= 1'b0;
      end else begin
        r_w       <= w_w_nx;
        r_l       <= w_l_nx;
        r_r       <= w_r_nx;
        r_fresh   <= w_fresh_nx;
        r_started <= w_started_nx;
        r_valid   <= w_valid_nx;
        r_wr_addr <= bank_addr(w_w_nx);
        r_rd_addr <= bank_addr(w_r_nx);
        r_load_o  <= w_wr_load[c];
        if (w_drop_inc && (r_drop != 8'hFF))
          r_drop <= r_drop + 8'd1;
      end
    end
  end

  always_ff @(posedge SDRAM_oCLK or posedge RST) begin
    if (RST) begin
      r_rd_load_o <= 1'b0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_rd_load_o <= RD1_LOAD;
      r_rd_valid  <= g_ch[0].w_valid_nx & g_ch[1].w_valid_nx;
    end
  end

  assign WR1_ADDR     = g_ch[0].r_wr_addr;
  assign WR2_ADDR     = g_ch[1].r_wr_addr;
  assign RD1_ADDR1    = g_ch[0].r_rd_addr;
  assign RD1_ADDR2    = g_ch[1].r_rd_addr;
  assign WR1_LOAD_O   = g_ch[0].r_load_o;
  assign WR2_LOAD_O   = g_ch[1].r_load_o;
  assign RD1_LOAD_O   = r_rd_load_o;
  assign RD1_VALID    = r_rd_valid;
  assign WR1_DROP_CNT = g_ch[0].r_drop;
  assign WR2_DROP_CNT = g_ch[1].r_drop;

endmodule
`default_nettype wire

// File: tb/tb_frame_bank_ctrl.sv
`default_nettype none
// Bench for frame_bank_ctrl: directed scenarios with literal expectations plus
// a per-cycle comparison against a bank-role model of both channels.
module tb_frame_bank_ctrl;
  localparam int BANK = 32'h100000;

  logic        SDRAM_oCLK = 1'b0;
  logic        RST = 1'b1;
  logic        WR1_LOAD = 1'b0, WR2_LOAD = 1'b0, RD1_LOAD = 1'b0;
  logic [23:0] WR1_ADDR, WR2_ADDR, RD1_ADDR1, RD1_ADDR2;
  logic        WR1_LOAD_O, WR2_LOAD_O, RD1_LOAD_O, RD1_VALID;
  logic [7:0]  WR1_DROP_CNT, WR2_DROP_CNT;

  int vectors = 0;
  int miscompares = 0;

  frame_bank_ctrl dut (
    .SDRAM_oCLK(SDRAM_oCLK), .RST(RST),
    .WR1_LOAD(WR1_LOAD), .WR2_LOAD(WR2_LOAD), .RD1_LOAD(RD1_LOAD),
    .WR1_ADDR(WR1_ADDR), .WR2_ADDR(WR2_ADDR),
    .RD1_ADDR1(RD1_ADDR1), .RD1_ADDR2(RD1_ADDR2),
    .WR1_LOAD_O(WR1_LOAD_O), .WR2_LOAD_O(WR2_LOAD_O), .RD1_LOAD_O(RD1_LOAD_O),
    .RD1_VALID(RD1_VALID), .WR1_DROP_CNT(WR1_DROP_CNT), .WR2_DROP_CNT(WR2_DROP_CNT)
  );

  always #5 SDRAM_oCLK = ~SDRAM_oCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel tracks which physical bank plays each role.
  int  m_wb[2], m_lb[2], m_rb[2], m_drop[2];
  bit  m_fresh[2], m_started[2], m_valid[2];
  bit  m_wl[2], m_rl;
  int  m_base[2] = '{32'h000000, 32'h300000};

  function automatic logic [31:0] bank_base(input int ch, input int bank);
    return (m_base[ch] + bank * BANK) & 32'h00FF_FFFF;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_wb[c] = 0; m_lb[c] = 1; m_rb[c] = 2; m_drop[c] = 0;
      m_fresh[c] = 0; m_started[c] = 0; m_valid[c] = 0; m_wl[c] = 0;
    end
    m_rl = 0;
  endtask

  task automatic model_step(input bit wr1, input bit wr2, input bit rd);
    bit wr[2];
    int t;
    wr[0] = wr1; wr[1] = wr2;
    for (int c = 0; c < 2; c++) begin
      if (wr[c] && !m_started[c]) m_started[c] = 1;
      else if (wr[c]) begin
        if (m_fresh[c] && m_drop[c] < 255) m_drop[c]++;
        t = m_wb[c]; m_wb[c] = m_lb[c]; m_lb[c] = t;
        m_fresh[c] = 1;
      end
      if (rd && m_fresh[c]) begin
        t = m_rb[c]; m_rb[c] = m_lb[c]; m_lb[c] = t;
        m_fresh[c] = 0; m_valid[c] = 1;
      end
      m_wl[c] = wr[c];
    end
    m_rl = rd;
  endtask

  initial model_reset();

  always @(posedge SDRAM_oCLK) begin
    if (RST) model_reset();
    else model_step(WR1_LOAD, WR2_LOAD, RD1_LOAD);
    #1;
    chk("WR1_ADDR", WR1_ADDR, bank_base(0, m_wb[0]));
    chk("WR2_ADDR", WR2_ADDR, bank_base(1, m_wb[1]));
    chk("RD1_ADDR1", RD1_ADDR1, bank_base(0, m_rb[0]));
    chk("RD1_ADDR2", RD1_ADDR2, bank_base(1, m_rb[1]));
    chk("WR1_LOAD_O", WR1_LOAD_O, m_wl[0]);
    chk("WR2_LOAD_O", WR2_LOAD_O, m_wl[1]);
    chk("RD1_LOAD_O", RD1_LOAD_O, m_rl);
    chk("RD1_VALID", RD1_VALID, m_valid[0] & m_valid[1]);
    chk("WR1_DROP_CNT", WR1_DROP_CNT, m_drop[0]);
    chk("WR2_DROP_CNT", WR2_DROP_CNT, m_drop[1]);
    chk("CH1_WR_NE_RD", (WR1_ADDR != RD1_ADDR1), 1);
    chk("CH2_WR_NE_RD", (WR2_ADDR != RD1_ADDR2), 1);
  end

  // One-cycle pulse; returns on the negedge after the sampling edge.
  task automatic pulse(input bit w1, input bit w2, input bit rd);
    @(negedge SDRAM_oCLK);
    WR1_LOAD = w1; WR2_LOAD = w2; RD1_LOAD = rd;
    @(negedge SDRAM_oCLK);
    WR1_LOAD = 0; WR2_LOAD = 0; RD1_LOAD = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_WR1_ADDR"}, WR1_ADDR, 32'h000000);
    chk({tag, "_RD1_ADDR1"}, RD1_ADDR1, 32'h200000);
    chk({tag, "_WR2_ADDR"}, WR2_ADDR, 32'h300000);
    chk({tag, "_RD1_ADDR2"}, RD1_ADDR2, 32'h500000);
    chk({tag, "_FLAGS"}, {WR1_LOAD_O, WR2_LOAD_O, RD1_LOAD_O, RD1_VALID}, 0);
    chk({tag, "_DROPS"}, {WR1_DROP_CNT, WR2_DROP_CNT}, 0);
  endtask

  task automatic mid_reset();
    @(negedge SDRAM_oCLK);
    RST = 1;
    #1;
    chk("ASYNC_RST_WR1_ADDR", WR1_ADDR, 32'h000000);
    @(negedge SDRAM_oCLK);
    RST = 0;
    check_reset_state("RST");
  endtask

  initial begin
    repeat (2) @(negedge SDRAM_oCLK);
    RST = 0;
    check_reset_state("POR");

    // Channel 1: open, complete, read
    pulse(1, 0, 0);
    chk("T2_WR1_LOAD_O", WR1_LOAD_O, 1);
    chk("T2_WR1_ADDR_OPEN", WR1_ADDR, 32'h000000);
    @(negedge SDRAM_oCLK);
    chk("T2_WR1_LOAD_O_FALL", WR1_LOAD_O, 0);
    pulse(1, 0, 0);
    chk("T2_WR1_ADDR_SWAP", WR1_ADDR, 32'h100000);
    pulse(0, 0, 1);
    chk("T2_RD1_ADDR1", RD1_ADDR1, 32'h000000);
    chk("T2_RD1_VALID", RD1_VALID, 0);

    // Channel 2 same, then repeat read with no new frames
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    chk("T3_WR2_ADDR", WR2_ADDR, 32'h400000);
    pulse(0, 0, 1);
    chk("T3_RD1_ADDR2", RD1_ADDR2, 32'h300000);
    chk("T3_RD1_VALID", RD1_VALID, 1);
    pulse(0, 0, 1);
    chk("T3_RD1_LOAD_O", RD1_LOAD_O, 1);
    chk("T3_HOLD_ADDR1", RD1_ADDR1, 32'h000000);
    chk("T3_HOLD_ADDR2", RD1_ADDR2, 32'h300000);

    // Mid-run reset, then drop counting and saturation
    mid_reset();
    repeat (4) pulse(1, 0, 0);
    chk("T4_DROP2", WR1_DROP_CNT, 2);
    for (int i = 0; i < 300; i++) begin
      @(negedge SDRAM_oCLK);
      WR1_LOAD = 1;
    end
    @(negedge SDRAM_oCLK);
    WR1_LOAD = 0;
    chk("T4_DROP_SAT", WR1_DROP_CNT, 255);

    // Simultaneous write completion and read from w0,l1,r2 with fresh set
    mid_reset();
    repeat (3) pulse(1, 0, 0);
    chk("T5_PRE_WR1_ADDR", WR1_ADDR, 32'h000000);
    pulse(1, 0, 1);
    chk("T5_RD1_ADDR1", RD1_ADDR1, 32'h000000);
    chk("T5_WR1_ADDR", WR1_ADDR, 32'h100000);
    chk("T5_RD1_VALID", RD1_VALID, 0);

    // Random back-to-back pulses
    for (int i = 0; i < 10000; i++) begin
      @(negedge SDRAM_oCLK);
      WR1_LOAD = ($urandom_range(0, 2) == 0);
      WR2_LOAD = ($urandom_range(0, 2) == 0);
      RD1_LOAD = ($urandom_range(0, 3) == 0);
    end
    @(negedge SDRAM_oCLK);
    WR1_LOAD = 0; WR2_LOAD = 0; RD1_LOAD = 0;
    repeat (3) @(negedge SDRAM_oCLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
